// File: rtl/instruction_fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_controller_pkg
// Description : Shared definitions for the instruction fetch controller:
//               fetch state encoding, instruction size and default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_controller_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } fetch_state_e;

  // Size of one instruction word in bytes
  localparam int unsigned INSTR_BYTES = 4;

  // Default program counter value after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : instruction_fetch_controller_pkg
`default_nettype wire

// File: rtl/instruction_fetch_controller_fetch_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_output_stage
// Description : Single-entry valid/ready register holding {instruction, pc}
//               for the decode stage. Supports load, flush and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_output_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;

  // Next-state: flush wins, then load, then drain on handshake; data only
  // changes on load so the word stays stable under backpressure.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Stage register with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule : fetch_output_stage
`default_nettype wire

// File: rtl/instruction_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_controller
// Description : Owns the program counter, drives the instruction memory read
//               address and feeds a valid/ready output stage to decode.
//               Handles redirects, halt requests and address faults, and
//               counts instructions accepted by decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] instruction_address_o,
  input  logic [31:0] instruction_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_instruction_o,
  output logic [31:0] fetch_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        halt_i,
  output logic        fault_o,
  output logic [31:0] fault_addr_o,
  output logic [31:0] fetch_count_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_addr_q, fault_addr_d;
  logic [31:0]  count_q, count_d;

  logic         stage_valid;
  logic         stage_load;
  logic         stage_flush;
  logic         can_load;
  logic         transfer;
  logic         pc_legal;
  logic [32:0]  last_byte;

  assign can_load = !stage_valid || fetch_ready_i;
  assign transfer = stage_valid && fetch_ready_i;

  // Legality is evaluated on 33 bits so a PC near 2^32 cannot wrap into range
  assign last_byte = {1'b0, pc_q} + 33'(INSTR_BYTES - 1);
  assign pc_legal  = (pc_q[1:0] == 2'b00) && (last_byte < 33'(MEM_BYTES));

  // Next-state and control: redirect overrides everything, otherwise the
  // current state decides whether a fetch is issued or a fault is raised.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    stage_load   = 1'b0;
    stage_flush  = 1'b0;
    if (redirect_valid_i) begin
      pc_d        = redirect_target_i;
      stage_flush = 1'b1;
      fault_d     = 1'b0;
      state_d     = halt_i ? ST_HALTED : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_i) begin
            state_d = ST_HALTED;
          end else if (can_load) begin
            if (pc_legal) begin
              stage_load = 1'b1;
              pc_d       = pc_q + 32'(INSTR_BYTES);
            end else begin
              state_d      = ST_FAULT;
              fault_d      = 1'b1;
              fault_addr_d = pc_q;
            end
          end
        end
        ST_HALTED: begin
          if (!halt_i) begin
            state_d = ST_RUN;
          end
        end
        ST_FAULT: begin
          // Parked until a redirect arrives
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Transfers count even in a redirect cycle since decode has taken the word
  always_comb begin
    count_d = count_q;
    if (transfer) begin
      count_d = count_q + 32'd1;
    end
  end

  // Controller state registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      count_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  fetch_output_stage u_output_stage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (stage_load),
    .flush_i (stage_flush),
    .ready_i (fetch_ready_i),
    .instr_i (instruction_i),
    .pc_i    (pc_q),
    .valid_o (stage_valid),
    .instr_o (fetch_instruction_o),
    .pc_o    (fetch_pc_o)
  );

  assign instruction_address_o = pc_q;
  assign fetch_valid_o         = stage_valid;
  assign fault_o               = fault_q;
  assign fault_addr_o          = fault_addr_q;
  assign fetch_count_o         = count_q;

endmodule : instruction_fetch_controller
`default_nettype wire
